xs_back1_rom_fetch: RTL and testbench
=====================================

// Module: xs_back1_rom_fetch
// PURPOSE
// - SDRAM-side fetch stage feeding the BACK1 tile layer's ROM port: accepts the layer's
//   ROM_req pulse + 17-bit word address, issues one SDRAM read, returns 16-bit ROM_data.
// - Sits between the BACK1 layer and the SDRAM arbiter channel; adds a 1-entry tag cache,
//   a 1-deep newest-wins pending slot and a read timeout, so a stalled arbiter never wedges video.
// PARAMETERS
// - ADDR_W      24          SDRAM word-address width
// - BASE_ADDR   24'h040000  SDRAM word offset of the BACK1 gfx region (4 x 32K x 16)
// - TIMEOUT     255         cycles sdr_req may wait for sdr_rdy before the read is abandoned
// - FILL_DATA   16'hFFFF    ROM_data value presented on timeout
// PORTS
// - clk           in   1       master clock, all logic on posedge
// - RESETn        in   1       async active-low reset
// - ROM_req       in   1       1-cycle request pulse from BACK1
// - req_ROM_addr  in   17      word address {bank[1:0], tile/row[14:0]}, valid with ROM_req
// - ROM_data      out  16      fetched word; held until next completion
// - ROM_valid     out  1       1-cycle pulse when ROM_data updates
// - sdr_addr      out  ADDR_W  BASE_ADDR + req_ROM_addr (zero-extended); stable while sdr_req=1
// - sdr_req       out  1       level read request to arbiter
// - sdr_rdy       in   1       1-cycle pulse: sdr_data valid, request retired
// - sdr_data      in   16      read data, sampled only when sdr_rdy=1
// - timeout_cnt   out  8       saturating count of abandoned reads (debug)
// BEHAVIOUR
// - Reset (async): ROM_data=16'h0, ROM_valid=0, sdr_req=0, sdr_addr=0, timeout_cnt=0,
//   cache tag invalid, pending slot empty, state IDLE. Reset mid-read drops sdr_req at once;
//   an sdr_rdy arriving after reset release while IDLE is ignored.
// - States: IDLE, ISSUE, DONE.
//   IDLE: request available (ROM_req or pending slot; ROM_req wins, slot cleared) ->
//     tag hit: ROM_data<=cached word, ROM_valid=1 next cycle, stay IDLE (1-cycle latency);
//     miss: latch sdr_addr, sdr_req<=1, wait counter<=0, -> ISSUE.
//   ISSUE: sdr_rdy=1 -> capture sdr_data into ROM_data + cache word, tag<=addr, tag valid,
//     sdr_req<=0, ROM_valid pulse, -> DONE. Counter reaches TIMEOUT with no sdr_rdy ->
//     sdr_req<=0, ROM_data<=FILL_DATA, ROM_valid pulse, tag invalid, timeout_cnt+1 (sat 255), -> DONE.
//   DONE: 1 idle cycle (sdr_req low >=1 cycle between reads) -> IDLE.
// - Miss latency: sdr_req rises 1 cycle after ROM_req; ROM_valid 1 cycle after sdr_rdy.
// - ROM_req while not IDLE: address stored in pending slot; a later ROM_req overwrites it
//   (newest wins, older dropped silently). A request equal to the in-flight address is
//   discarded (served by the in-flight completion).
// - ROM_req in the same cycle as sdr_rdy: completion handled, new request goes to pending,
//   issued from IDLE after DONE.
// - sdr_rdy outside ISSUE: ignored. Address arithmetic: ADDR_W-bit add, carry-out discarded.
// STRUCTURE
// - Package xs_rom_pkg: typedef enum logic [1:0] {IDLE, ISSUE, DONE} fetch_state_t;
//   localparam BACK1 BASE_ADDR and FILL_DATA constants shared with other layer fetchers.
// - No sub-module: FSM, wait counter, tag/data cache and pending slot all in one always_ff.
// TESTING
// - Miss: ROM_req addr 17'h00123, sdr_rdy 5 cycles later with 16'hBEEF -> sdr_addr=24'h040123,
//   sdr_req high 5 cycles, ROM_data=16'hBEEF with ROM_valid 1 cycle after sdr_rdy.
// - Hit: repeat addr 17'h00123 after completion -> no sdr_req, ROM_valid next cycle, data 16'hBEEF.
// - Newest wins: req 0x10 issued; while ISSUE send 0x20 then 0x30 -> after completion only
//   0x30 fetched (sdr_addr=24'h040030); 0x20 never appears on sdr_addr.
// - Timeout: ROM_req, never assert sdr_rdy -> sdr_req drops after 255 cycles,
//   ROM_data=16'hFFFF, timeout_cnt=1; repeat same addr -> refetch (cache invalid).
// - Collision: ROM_req 0x44 in same cycle as sdr_rdy for 0x40 -> 0x40 data delivered,
//   0x44 issued after DONE cycle.
// - Reset mid-ISSUE: pull RESETn low -> sdr_req=0 same cycle, all outputs at reset values;
//   stray sdr_rdy after release -> no ROM_valid.

Source files
------------

// File: rtl/xs_rom_pkg.sv
// rtl/xs_rom_pkg.sv - shared types and constants for the tile-layer ROM fetchers
//
// Purpose: fetch FSM state encoding plus the BACK1 SDRAM region base and the
// word returned when a read is abandoned. Other layer fetchers reuse these.
package xs_rom_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  // BACK1 gfx lives in 4 banks of 32K x 16 starting at this SDRAM word offset.
  localparam logic [23:0] BACK1_BASE_ADDR = 24'h040000;
  localparam logic [15:0] BACK1_FILL_DATA = 16'hFFFF;

endpackage

// File: rtl/xs_back1_rom_fetch.sv
// rtl/xs_back1_rom_fetch.sv - BACK1 ROM port to SDRAM arbiter fetch stage
//
// Purpose: turns the BACK1 layer's ROM_req pulse into one SDRAM read, with a
// 1-entry tag cache, a 1-deep newest-wins pending slot and a read timeout so
// a stalled arbiter never wedges video.
//
// Ports:
//   clk          in   master clock, posedge
//   RESETn       in   async active-low reset
//   ROM_req      in   1-cycle request pulse
//   req_ROM_addr in   17-bit word address, valid with ROM_req
//   ROM_data     out  fetched word, held until the next completion
//   ROM_valid    out  1-cycle pulse when ROM_data updates
//   sdr_addr     out  BASE_ADDR + req_ROM_addr, stable while sdr_req=1
//   sdr_req      out  level read request to the arbiter
//   sdr_rdy      in   1-cycle pulse, sdr_data valid and request retired
//   sdr_data     in   read data
//   timeout_cnt  out  saturating count of abandoned reads
module xs_back1_rom_fetch
  import xs_rom_pkg::*;
#(
  parameter int                 ADDR_W    = 24,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(BACK1_BASE_ADDR),
  parameter int                 TIMEOUT   = 255,
  parameter logic [15:0]        FILL_DATA = BACK1_FILL_DATA
) (
  input  logic              clk,
  input  logic              RESETn,
  input  logic              ROM_req,
  input  logic [16:0]       req_ROM_addr,
  output logic [15:0]       ROM_data,
  output logic              ROM_valid,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic              sdr_req,
  input  logic              sdr_rdy,
  input  logic [15:0]       sdr_data,
  output logic [7:0]        timeout_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  fetch_state_t      state_q, state_d;
  logic [15:0]       rom_data_q, rom_data_d;
  logic              rom_valid_q, rom_valid_d;
  logic [ADDR_W-1:0] sdr_addr_q, sdr_addr_d;
  logic              sdr_req_q, sdr_req_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic [16:0]       tag_q, tag_d;
  logic              tag_vld_q, tag_vld_d;
  logic [15:0]       cache_q, cache_d;
  logic [16:0]       fly_addr_q, fly_addr_d;
  logic              pend_vld_q, pend_vld_d;
  logic [16:0]       pend_addr_q, pend_addr_d;

  logic        req_vld;
  logic [16:0] req_addr;

  // A fresh request always beats whatever is parked in the pending slot.
  assign req_vld  = ROM_req | pend_vld_q;
  assign req_addr = ROM_req ? req_ROM_addr : pend_addr_q;

  always_comb begin
    state_d     = state_q;
    rom_data_d  = rom_data_q;
    rom_valid_d = 1'b0;
    sdr_addr_d  = sdr_addr_q;
    sdr_req_d   = sdr_req_q;
    wait_d      = wait_q;
    tmo_cnt_d   = tmo_cnt_q;
    tag_d       = tag_q;
    tag_vld_d   = tag_vld_q;
    cache_d     = cache_q;
    fly_addr_d  = fly_addr_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;

    case (state_q)
      IDLE: begin
        if (req_vld) begin
          pend_vld_d = 1'b0;
          if (tag_vld_q && (tag_q == req_addr)) begin
            rom_data_d  = cache_q;
            rom_valid_d = 1'b1;
          end else begin
            sdr_addr_d = BASE_ADDR + ADDR_W'(req_addr);
            fly_addr_d = req_addr;
            sdr_req_d  = 1'b1;
            wait_d     = '0;
            state_d    = ISSUE;
          end
        end
      end

      ISSUE: begin
        // Same address as the read in flight will be satisfied by its completion.
        if (ROM_req && (req_ROM_addr != fly_addr_q)) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = req_ROM_addr;
        end
        if (sdr_rdy) begin
          rom_data_d  = sdr_data;
          rom_valid_d = 1'b1;
          cache_d     = sdr_data;
          tag_d       = fly_addr_q;
          tag_vld_d   = 1'b1;
          sdr_req_d   = 1'b0;
          state_d     = DONE;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          // sdr_req has now been high for TIMEOUT cycles; give up on this read.
          rom_data_d  = FILL_DATA;
          rom_valid_d = 1'b1;
          tag_vld_d   = 1'b0;
          sdr_req_d   = 1'b0;
          if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
          state_d     = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      DONE: begin
        // Guarantees sdr_req is low for at least one cycle between reads.
        if (ROM_req) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = req_ROM_addr;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= IDLE;
      rom_data_q  <= 16'h0;
      rom_valid_q <= 1'b0;
      sdr_addr_q  <= '0;
      sdr_req_q   <= 1'b0;
      wait_q      <= '0;
      tmo_cnt_q   <= 8'h0;
      tag_q       <= 17'h0;
      tag_vld_q   <= 1'b0;
      cache_q     <= 16'h0;
      fly_addr_q  <= 17'h0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= 17'h0;
    end else begin
      state_q     <= state_d;
      rom_data_q  <= rom_data_d;
      rom_valid_q <= rom_valid_d;
      sdr_addr_q  <= sdr_addr_d;
      sdr_req_q   <= sdr_req_d;
      wait_q      <= wait_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tag_q       <= tag_d;
      tag_vld_q   <= tag_vld_d;
      cache_q     <= cache_d;
      fly_addr_q  <= fly_addr_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign ROM_data    = rom_data_q;
  assign ROM_valid   = rom_valid_q;
  assign sdr_addr    = sdr_addr_q;
  assign sdr_req     = sdr_req_q;
  assign timeout_cnt = tmo_cnt_q;

endmodule

// File: tb/tb_xs_back1_rom_fetch.sv
// tb/tb_xs_back1_rom_fetch.sv - directed self-checking bench for xs_back1_rom_fetch
module tb_xs_back1_rom_fetch;

  logic        clk = 1'b0;
  logic        RESETn;
  logic        ROM_req;
  logic [16:0] req_ROM_addr;
  logic [15:0] ROM_data;
  logic        ROM_valid;
  logic [23:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_rdy;
  logic [15:0] sdr_data;
  logic [7:0]  timeout_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic seen_20 = 1'b0;

  xs_back1_rom_fetch dut (
    .clk         (clk),
    .RESETn      (RESETn),
    .ROM_req     (ROM_req),
    .req_ROM_addr(req_ROM_addr),
    .ROM_data    (ROM_data),
    .ROM_valid   (ROM_valid),
    .sdr_addr    (sdr_addr),
    .sdr_req     (sdr_req),
    .sdr_rdy     (sdr_rdy),
    .sdr_data    (sdr_data),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sdr_req && sdr_addr == 24'h040020) seen_20 = 1'b1;
  end

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RESETn = 1'b0; ROM_req = 1'b0; req_ROM_addr = '0; sdr_rdy = 1'b0; sdr_data = '0;
    step(); step();
    n_checks++;
    if ({ROM_data, ROM_valid, sdr_req, sdr_addr, timeout_cnt} !== 50'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b req=%b addr=%h tmo=%h expected all zero",
               ROM_data, ROM_valid, sdr_req, sdr_addr, timeout_cnt);
    end
    RESETn = 1'b1;
    step();
  endtask

  task automatic test_miss();
    bit req_ok = 1'b1;
    ROM_req = 1'b1; req_ROM_addr = 17'h00123;
    step();
    ROM_req = 1'b0;
    n_checks++;
    if (sdr_req !== 1'b1 || sdr_addr !== 24'h040123) begin
      n_fail++;
      $display("FAIL miss_issue: got req=%b addr=%h expected req=1 addr=040123", sdr_req, sdr_addr);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      if (sdr_req !== 1'b1 || ROM_valid !== 1'b0) req_ok = 1'b0;
    end
    n_checks++;
    if (!req_ok) begin
      n_fail++;
      $display("FAIL miss_req_held: got sdr_req dropped or early ROM_valid expected req high 5 cycles");
    end
    sdr_rdy = 1'b1; sdr_data = 16'hBEEF;
    step();
    sdr_rdy = 1'b0;
    n_checks++;
    if (ROM_valid !== 1'b1 || ROM_data !== 16'hBEEF || sdr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_complete: got v=%b data=%h req=%b expected v=1 data=beef req=0",
               ROM_valid, ROM_data, sdr_req);
    end
    step();
    n_checks++;
    if (ROM_valid !== 1'b0 || ROM_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL miss_pulse: got v=%b data=%h expected v=0 data=beef", ROM_valid, ROM_data);
    end
    step();
  endtask

  task automatic test_hit();
    ROM_req = 1'b1; req_ROM_addr = 17'h00123;
    step();
    ROM_req = 1'b0;
    n_checks++;
    if (ROM_valid !== 1'b1 || ROM_data !== 16'hBEEF || sdr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hit: got v=%b data=%h req=%b expected v=1 data=beef req=0",
               ROM_valid, ROM_data, sdr_req);
    end
    step();
    n_checks++;
    if (ROM_valid !== 1'b0 || sdr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_after: got v=%b req=%b expected v=0 req=0", ROM_valid, sdr_req);
    end
  endtask

  task automatic test_newest_wins();
    ROM_req = 1'b1; req_ROM_addr = 17'h00010;
    step();
    req_ROM_addr = 17'h00020;
    step();
    req_ROM_addr = 17'h00030;
    step();
    ROM_req = 1'b0;
    n_checks++;
    if (sdr_addr !== 24'h040010 || sdr_req !== 1'b1) begin
      n_fail++;
      $display("FAIL nw_first: got addr=%h req=%b expected addr=040010 req=1", sdr_addr, sdr_req);
    end
    sdr_rdy = 1'b1; sdr_data = 16'h1111;
    step();
    sdr_rdy = 1'b0;
    n_checks++;
    if (ROM_valid !== 1'b1 || ROM_data !== 16'h1111) begin
      n_fail++;
      $display("FAIL nw_first_data: got v=%b data=%h expected v=1 data=1111", ROM_valid, ROM_data);
    end
    step(); step();
    n_checks++;
    if (sdr_req !== 1'b1 || sdr_addr !== 24'h040030) begin
      n_fail++;
      $display("FAIL nw_pending: got req=%b addr=%h expected req=1 addr=040030", sdr_req, sdr_addr);
    end
    sdr_rdy = 1'b1; sdr_data = 16'h3333;
    step();
    sdr_rdy = 1'b0;
    n_checks++;
    if (ROM_valid !== 1'b1 || ROM_data !== 16'h3333) begin
      n_fail++;
      $display("FAIL nw_second_data: got v=%b data=%h expected v=1 data=3333", ROM_valid, ROM_data);
    end
    step(); step(); step();
    n_checks++;
    if (seen_20 !== 1'b0 || sdr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL nw_dropped: got seen_20=%b req=%b expected 0 0", seen_20, sdr_req);
    end
  endtask

  task automatic test_timeout();
    bit req_ok = 1'b1;
    ROM_req = 1'b1; req_ROM_addr = 17'h00055;
    step();
    ROM_req = 1'b0;
    for (int i = 1; i <= 254; i++) begin
      if (sdr_req !== 1'b1 || ROM_valid !== 1'b0) req_ok = 1'b0;
      step();
    end
    n_checks++;
    if (!req_ok || sdr_req !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_hold: got early drop (last req=%b) expected req high 255 cycles", sdr_req);
    end
    step();
    n_checks++;
    if (sdr_req !== 1'b0 || ROM_valid !== 1'b1 || ROM_data !== 16'hFFFF || timeout_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL tmo_abandon: got req=%b v=%b data=%h tmo=%0d expected 0 1 ffff 1",
               sdr_req, ROM_valid, ROM_data, timeout_cnt);
    end
    step(); step();
    ROM_req = 1'b1; req_ROM_addr = 17'h00055;
    step();
    ROM_req = 1'b0;
    n_checks++;
    if (sdr_req !== 1'b1 || sdr_addr !== 24'h040055 || ROM_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_refetch: got req=%b addr=%h v=%b expected 1 040055 0", sdr_req, sdr_addr, ROM_valid);
    end
    sdr_rdy = 1'b1; sdr_data = 16'h5555;
    step();
    sdr_rdy = 1'b0;
    step(); step();
  endtask

  task automatic test_collision();
    ROM_req = 1'b1; req_ROM_addr = 17'h00040;
    step();
    ROM_req = 1'b0;
    step(); step();
    sdr_rdy = 1'b1; sdr_data = 16'h4040;
    ROM_req = 1'b1; req_ROM_addr = 17'h00044;
    step();
    sdr_rdy = 1'b0; ROM_req = 1'b0;
    n_checks++;
    if (ROM_valid !== 1'b1 || ROM_data !== 16'h4040 || sdr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL col_data: got v=%b data=%h req=%b expected 1 4040 0", ROM_valid, ROM_data, sdr_req);
    end
    step();
    n_checks++;
    if (sdr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL col_done_gap: got req=%b expected 0", sdr_req);
    end
    step();
    n_checks++;
    if (sdr_req !== 1'b1 || sdr_addr !== 24'h040044) begin
      n_fail++;
      $display("FAIL col_issue: got req=%b addr=%h expected 1 040044", sdr_req, sdr_addr);
    end
    sdr_rdy = 1'b1; sdr_data = 16'h4444;
    step();
    sdr_rdy = 1'b0;
    step(); step();
  endtask

  task automatic test_reset_mid_issue();
    ROM_req = 1'b1; req_ROM_addr = 17'h00077;
    step();
    ROM_req = 1'b0;
    step();
    RESETn = 1'b0;
    #1;
    n_checks++;
    if ({ROM_data, ROM_valid, sdr_req, sdr_addr, timeout_cnt} !== 50'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got data=%h v=%b req=%b addr=%h tmo=%h expected all zero",
               ROM_data, ROM_valid, sdr_req, sdr_addr, timeout_cnt);
    end
    step();
    RESETn = 1'b1;
    step();
    sdr_rdy = 1'b1; sdr_data = 16'hDEAD;
    step();
    sdr_rdy = 1'b0;
    n_checks++;
    if (ROM_valid !== 1'b0 || ROM_data !== 16'h0 || sdr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stray_rdy: got v=%b data=%h req=%b expected 0 0000 0", ROM_valid, ROM_data, sdr_req);
    end
    // Cache was invalidated by reset, so a former hit address must refetch.
    ROM_req = 1'b1; req_ROM_addr = 17'h00123;
    step();
    ROM_req = 1'b0;
    n_checks++;
    if (sdr_req !== 1'b1 || ROM_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cache_inval: got req=%b v=%b expected 1 0", sdr_req, ROM_valid);
    end
    sdr_rdy = 1'b1; sdr_data = 16'hBEEF;
    step();
    sdr_rdy = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_newest_wins();
    test_timeout();
    test_collision();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
